// File: rtl/if_stage_pkg.sv
// Shared widths, stall encodings and fetch-FSM states for the IF stage.
package if_stage_pkg;

  localparam int IF_TO_ID_WD = 33;
  localparam int BR_WD       = 33;
  localparam int StallBus    = 6;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/if_stage_redir_latch.sv
// Holds a branch target raised while IF is stalled until the stall releases.
module if_redir_latch
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_capture,
  input  logic [31:0] i_addr,
  input  logic        i_clear,
  output logic        o_redir_v,
  output logic [31:0] o_redir_addr
);

  logic        r_redir_v;
  logic [31:0] r_redir_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_redir_v <= 1'b0;
    end else if (i_capture) begin
      r_redir_v <= 1'b1;
    end else if (i_clear) begin
      r_redir_v <= 1'b0;
    end
  end

  // Target is qualified by r_redir_v, so it needs no reset; latest capture wins.
  always_ff @(posedge clk) begin
    if (i_capture) begin
      r_redir_addr <= i_addr;
    end
  end

  assign o_redir_v    = r_redir_v;
  assign o_redir_addr = r_redir_addr;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch enable, SRAM port and branch redirects.
// Optional misaligned-fetch flag enabled by defining IF_ADEL_CHECK_EN.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
  parameter int          STALL_W  = StallBus
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata
`ifdef IF_ADEL_CHECK_EN
  ,output logic                  if_excp_adel
`endif
);

  localparam logic [31:0] BOOT_PC = RESET_PC + 32'd4;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic        r_ce;

  logic        w_br_e;
  logic [31:0] w_br_addr;
  logic        w_stall_pc;
  logic        w_boot;
  logic        w_advance;
  logic        w_capture;
  logic        w_redir_v;
  logic [31:0] w_redir_addr;
  logic [31:0] w_next_pc;
  logic        w_unused_stall;

  assign w_br_e         = br_bus[32];
  assign w_br_addr      = br_bus[31:0];
  assign w_stall_pc     = stall[0];
  assign w_unused_stall = |stall[STALL_W-1:1];

  if_redir_latch u_redir (
    .clk          (clk),
    .rst          (rst),
    .i_capture    (w_capture),
    .i_addr       (w_br_addr),
    .i_clear      (w_advance),
    .o_redir_v    (w_redir_v),
    .o_redir_addr (w_redir_addr)
  );

  // A live branch beats a held redirect, which beats sequential fetch.
  assign w_next_pc = w_br_e    ? w_br_addr    :
                     w_redir_v ? w_redir_addr :
                                 r_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_boot      = 1'b0;
    w_advance   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_BOOT: begin
        if (w_stall_pc == NoStop) begin
          w_boot      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_stall_pc == NoStop) begin
          w_advance = 1'b1;
        end else if (w_br_e) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_stall_pc == NoStop) begin
          w_advance   = 1'b1;
          w_state_nxt = S_RUN;
        end else if (w_br_e) begin
          w_capture = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
      r_ce <= 1'b0;
    end else if (w_boot) begin
      r_pc <= BOOT_PC;
      r_ce <= 1'b1;
    end else if (w_advance) begin
      r_pc <= w_next_pc;
    end
  end

  assign if_to_id_bus    = {r_ce, r_pc};
  assign inst_sram_addr  = r_pc;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'h0;

`ifdef IF_ADEL_CHECK_EN
  // The PC keeps advancing on a misaligned fetch; only the SRAM access is suppressed.
  assign if_excp_adel = r_ce & (r_pc[1:0] != 2'b00);
  assign inst_sram_en = r_ce & ~if_excp_adel;
`else
  assign inst_sram_en = r_ce;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic vs. a fetch model.
module tb_if_stage;

  localparam logic [31:0] RST_PC  = 32'hBFBF_FFFC;
  localparam logic [31:0] BOOT_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
`ifdef IF_ADEL_CHECK_EN
  logic        if_excp_adel;
`endif

  int total = 0;
  int bad   = 0;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata)
`ifdef IF_ADEL_CHECK_EN
    ,.if_excp_adel   (if_excp_adel)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Fetch model: booted flag, current PC, and at most one pending redirect target.
  logic        m_valid  = 1'b0;
  logic        m_booted = 1'b0;
  logic [31:0] m_pc     = 32'h0;
  logic        m_pend   = 1'b0;
  logic [31:0] m_paddr  = 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b1;
      m_booted <= 1'b0;
      m_pc     <= RST_PC;
      m_pend   <= 1'b0;
    end else if (m_valid) begin
      if (!m_booted) begin
        if (!stall[0]) begin
          m_booted <= 1'b1;
          m_pc     <= BOOT_PC;
        end
      end else if (stall[0]) begin
        if (br_bus[32]) begin
          m_pend  <= 1'b1;
          m_paddr <= br_bus[31:0];
        end
      end else begin
        m_pc   <= br_bus[32] ? br_bus[31:0] : (m_pend ? m_paddr : m_pc + 32'd4);
        m_pend <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic adel;
      adel = 1'b0;
`ifdef IF_ADEL_CHECK_EN
      adel = m_booted && (m_pc[1:0] != 2'b00);
      check("cmp_adel", 64'(if_excp_adel), 64'(adel));
`endif
      check("cmp_bus", 64'(if_to_id_bus), 64'({m_booted, m_pc}));
      check("cmp_addr", 64'(inst_sram_addr), 64'(m_pc));
      check("cmp_en", 64'(inst_sram_en), 64'(m_booted && !adel));
      check("cmp_wen", 64'(inst_sram_wen), 64'(4'b0000));
      check("cmp_wdata", 64'(inst_sram_wdata), 64'(32'h0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s0, input logic be, input logic [31:0] ba);
    stall  = {5'b0, s0};
    br_bus = {be, ba};
  endtask

  task automatic expect_pc(input string name, input logic ce, input logic [31:0] pc);
    check(name, 64'(if_to_id_bus), 64'({ce, pc}));
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    repeat (3) step();
    check("rst_bus", 64'(if_to_id_bus), 64'(33'h0_BFBF_FFFC));
    check("rst_en", 64'(inst_sram_en), 64'(1'b0));
    check("rst_addr", 64'(inst_sram_addr), 64'(RST_PC));

    // Boot: branch ignored while stalled in boot, then sequential fetch
    rst = 1'b0;
    drive(1'b1, 1'b1, 32'h1234_0000);
    step(); expect_pc("boot_ignore_br", 1'b0, RST_PC);
    drive(1'b0, 1'b0, 32'h0);
    step(); expect_pc("t1_pc0", 1'b1, 32'hBFC0_0000);
    step(); expect_pc("t1_pc1", 1'b1, 32'hBFC0_0004);
    step(); expect_pc("t1_pc2", 1'b1, 32'hBFC0_0008);
    step(); step(); expect_pc("t1_pc4", 1'b1, 32'hBFC0_0010);

    // Branch redirect
    drive(1'b0, 1'b1, 32'hBFC0_0100);
    step(); expect_pc("t2_br", 1'b1, 32'hBFC0_0100);
    drive(1'b0, 1'b0, 32'h0);
    step(); expect_pc("t2_seq", 1'b1, 32'hBFC0_0104);

    // Redirect held through a 4-cycle stall
    drive(1'b1, 1'b1, 32'hBFC0_0200);
    step(); expect_pc("t3_frz1", 1'b1, 32'hBFC0_0104);
    drive(1'b1, 1'b0, 32'h0);
    step(); step(); step(); expect_pc("t3_frz4", 1'b1, 32'hBFC0_0104);
    drive(1'b0, 1'b0, 32'h0);
    step(); expect_pc("t3_use", 1'b1, 32'hBFC0_0200);
    step(); expect_pc("t3_once", 1'b1, 32'hBFC0_0204);

    // Live branch on release beats held redirect
    drive(1'b1, 1'b1, 32'hBFC0_0200);
    step(); expect_pc("t4_hold", 1'b1, 32'hBFC0_0204);
    drive(1'b1, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b1, 32'hBFC0_0300);
    step(); expect_pc("t4_prio", 1'b1, 32'hBFC0_0300);
    drive(1'b0, 1'b0, 32'h0);
    step(); expect_pc("t4_after", 1'b1, 32'hBFC0_0304);

    // Wrap, then reset while a redirect is pending
    drive(1'b0, 1'b1, 32'hFFFF_FFF8);
    step();
    drive(1'b0, 1'b0, 32'h0);
    step(); expect_pc("t5_fffc", 1'b1, 32'hFFFF_FFFC);
    step(); expect_pc("t5_wrap", 1'b1, 32'h0000_0000);
    drive(1'b1, 1'b1, 32'hBFC0_0400);
    step(); expect_pc("t5_hold", 1'b1, 32'h0000_0000);
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    step(); expect_pc("t5_rst", 1'b0, RST_PC);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    step(); expect_pc("t5_discard", 1'b1, 32'hBFC0_0000);
    step(); expect_pc("t5_seq", 1'b1, 32'hBFC0_0004);

`ifdef IF_ADEL_CHECK_EN
    drive(1'b0, 1'b1, 32'hBFC0_0102);
    step();
    check("t6_adel0", 64'(if_excp_adel), 64'(1'b1));
    check("t6_en0", 64'(inst_sram_en), 64'(1'b0));
    drive(1'b0, 1'b0, 32'h0);
    step();
    expect_pc("t6_pc1", 1'b1, 32'hBFC0_0106);
    check("t6_adel1", 64'(if_excp_adel), 64'(1'b1));
    drive(1'b0, 1'b1, 32'hBFC0_0200);
    step();
    check("t6_clear", 64'(if_excp_adel), 64'(1'b0));
    check("t6_en2", 64'(inst_sram_en), 64'(1'b1));
`endif

    // Randomized traffic; the negedge compare process checks every cycle
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      stall = 6'($urandom);
      stall[0] = ($urandom_range(0, 99) < 35);
      a = $urandom;
`ifndef IF_ADEL_CHECK_EN
      a = a & 32'hFFFF_FFFC;
`endif
      if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFF4;
      br_bus = {($urandom_range(0, 99) < 20), a};
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
